// File: rtl/tok_hash_table_pkg.sv
// ============================================================================
// Module : tok_hash_table_pkg
// Brief  : Shared encodings for the TOK key/value hash table engine:
//          request opcodes, per-slot state and FSM states.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tok_hash_table_pkg;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_INSERT = 2'd1,
        OP_DELETE = 2'd2,
        OP_CLEAR  = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'd0,
        SLOT_USED  = 2'd1,
        SLOT_TOMB  = 2'd2
    } slot_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CMP  = 3'd2,
        ST_WR   = 3'd3,
        ST_RSP  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/tok_hash_table_if.sv
// ============================================================================
// Module : tok_hash_table_if
// Brief  : Request/response bundle between the TOK decoder (master) and the
//          hash table engine (slave).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface tok_hash_table_if #(
    parameter int KEY_W = 16,
    parameter int VAL_W = 16,
    parameter int IDX_W = 8
) ();
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [KEY_W-1:0] req_key;
    logic [VAL_W-1:0] req_val;
    logic             rsp_valid;
    logic             rsp_hit;
    logic             rsp_full;
    logic [VAL_W-1:0] rsp_val;
    logic [IDX_W:0]   count;

    modport master (
        output req_valid, req_op, req_key, req_val,
        input  req_ready, rsp_valid, rsp_hit, rsp_full, rsp_val, count
    );

    modport slave (
        input  req_valid, req_op, req_key, req_val,
        output req_ready, rsp_valid, rsp_hit, rsp_full, rsp_val, count
    );
endinterface

`default_nettype wire

// File: rtl/tok_hash_table_fold.sv
// ============================================================================
// Module : tok_hash_table_fold
// Brief  : Home index of a key: XOR of its IDX_W-bit chunks, with the top
//          chunk zero-padded.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tok_hash_table_fold #(
    parameter int KEY_W = 16,
    parameter int IDX_W = 8
) (
    input  logic [KEY_W-1:0] key,
    output logic [IDX_W-1:0] idx
);
    localparam int NCHUNK = (KEY_W + IDX_W - 1) / IDX_W;

    logic [NCHUNK*IDX_W-1:0] padded;

    // Zero-extend the key to a whole number of chunks, then fold
    always_comb begin
        padded            = '0;
        padded[KEY_W-1:0] = key;
        idx               = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            idx = idx ^ padded[i*IDX_W +: IDX_W];
        end
    end
endmodule

`default_nettype wire

// File: rtl/tok_hash_table_ram.sv
// ============================================================================
// Module : tok_hash_table_ram
// Brief  : Single-port RAM with synchronous (1-cycle) read; used for the key
//          and value arrays.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tok_hash_table_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write-first is irrelevant: the controller never consumes a read of the slot being written
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end
endmodule

`default_nettype wire

// File: rtl/tok_hash_table.sv
// ============================================================================
// Module : tok_hash_table
// Brief  : Linear-probe key/value table with insert-or-update, tombstone
//          delete, probe limit with full reporting, one-cycle clear and an
//          occupancy count. Slot states live in flops, keys/values in RAM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tok_hash_table
    import tok_hash_table_pkg::*;
#(
    parameter int KEY_W     = 16,
    parameter int VAL_W     = 16,
    parameter int IDX_W     = 8,
    parameter int MAX_PROBE = 2**IDX_W
) (
    input  logic               clk,
    input  logic               reset,
    tok_hash_table_if.slave    bus
);
    localparam int             DEPTH      = 2**IDX_W;
    localparam logic [IDX_W:0] LAST_PROBE = (IDX_W+1)'(MAX_PROBE - 1);

    state_t           state;
    op_t              op;
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] tomb_idx;
    logic             tomb_seen;
    logic [IDX_W:0]   probes;
    logic             hit_p;
    logic             full_p;
    logic [VAL_W-1:0] val_p;
    slot_t            slot_st [DEPTH];
    logic [IDX_W:0]   count;
    logic             rsp_valid;
    logic             rsp_hit;
    logic             rsp_full;
    logic [VAL_W-1:0] rsp_val;

    logic [IDX_W-1:0] home;
    logic [KEY_W-1:0] key_rd;
    logic [VAL_W-1:0] val_rd;
    logic             ram_we;
    slot_t            cur;
    logic             match;
    logic             last;

    tok_hash_table_fold #(.KEY_W(KEY_W), .IDX_W(IDX_W)) u_fold (
        .key (bus.req_key),
        .idx (home)
    );

    // The RAM address is always idx: probing reads it, and the write target is parked in idx before WR
    tok_hash_table_ram #(.DATA_W(KEY_W), .ADDR_W(IDX_W)) u_keys (
        .clk   (clk),
        .we    (ram_we),
        .addr  (idx),
        .wdata (key),
        .rdata (key_rd)
    );

    tok_hash_table_ram #(.DATA_W(VAL_W), .ADDR_W(IDX_W)) u_vals (
        .clk   (clk),
        .we    (ram_we),
        .addr  (idx),
        .wdata (val),
        .rdata (val_rd)
    );

    assign ram_we        = (state == ST_WR) && !reset;
    assign cur           = slot_st[idx];
    assign match         = (key_rd == key);
    assign last          = (probes == LAST_PROBE);
    assign bus.req_ready = (state == ST_IDLE);
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_hit   = rsp_hit;
    assign bus.rsp_full  = rsp_full;
    assign bus.rsp_val   = rsp_val;
    assign bus.count     = count;

    // Request FSM: accept, probe (RD/CMP pairs), optional write, then a one-cycle response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            op        <= OP_LOOKUP;
            key       <= '0;
            val       <= '0;
            idx       <= '0;
            tomb_idx  <= '0;
            tomb_seen <= 1'b0;
            probes    <= '0;
            hit_p     <= 1'b0;
            full_p    <= 1'b0;
            val_p     <= '0;
            count     <= '0;
            rsp_valid <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_full  <= 1'b0;
            rsp_val   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_st[i] <= SLOT_EMPTY;
            end
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        op        <= op_t'(bus.req_op);
                        key       <= bus.req_key;
                        val       <= bus.req_val;
                        idx       <= home;
                        probes    <= '0;
                        tomb_seen <= 1'b0;
                        hit_p     <= 1'b0;
                        full_p    <= 1'b0;
                        val_p     <= '0;
                        if (op_t'(bus.req_op) == OP_CLEAR) begin
                            for (int i = 0; i < DEPTH; i++) begin
                                slot_st[i] <= SLOT_EMPTY;
                            end
                            count <= '0;
                            state <= ST_RSP;
                        end else begin
                            state <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    state <= ST_CMP;
                end
                ST_CMP: begin
                    if (op == OP_INSERT) begin
                        if (cur == SLOT_USED && match) begin
                            hit_p <= 1'b1;
                            state <= ST_WR;
                        end else if (cur == SLOT_EMPTY) begin
                            if (tomb_seen) begin
                                idx <= tomb_idx;
                            end
                            state <= ST_WR;
                        end else if (last) begin
                            if (tomb_seen) begin
                                idx   <= tomb_idx;
                                state <= ST_WR;
                            end else if (cur == SLOT_TOMB) begin
                                state <= ST_WR;
                            end else begin
                                full_p <= 1'b1;
                                state  <= ST_RSP;
                            end
                        end else begin
                            if (cur == SLOT_TOMB && !tomb_seen) begin
                                tomb_seen <= 1'b1;
                                tomb_idx  <= idx;
                            end
                            idx    <= idx + 1'b1;
                            probes <= probes + 1'b1;
                            state  <= ST_RD;
                        end
                    end else begin
                        if (cur == SLOT_USED && match) begin
                            hit_p <= 1'b1;
                            if (op == OP_LOOKUP) begin
                                val_p <= val_rd;
                            end else begin
                                slot_st[idx] <= SLOT_TOMB;
                                count        <= count - 1'b1;
                            end
                            state <= ST_RSP;
                        end else if (cur == SLOT_EMPTY || last) begin
                            state <= ST_RSP;
                        end else begin
                            idx    <= idx + 1'b1;
                            probes <= probes + 1'b1;
                            state  <= ST_RD;
                        end
                    end
                end
                ST_WR: begin
                    slot_st[idx] <= SLOT_USED;
                    if (!hit_p) begin
                        count <= count + 1'b1;
                    end
                    state <= ST_RSP;
                end
                ST_RSP: begin
                    rsp_valid <= 1'b1;
                    rsp_hit   <= hit_p;
                    rsp_full  <= full_p;
                    rsp_val   <= val_p;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

`default_nettype wire
